mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-way arbiter (fetch / data / debug) in front of a single-port
// synchronous RAM, with a starvation promotion for instruction fetch.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    input  logic        g_req,
    input  logic        g_we,
    input  logic [15:0] g_addr,
    input  logic [15:0] g_wdata,
    output logic        g_ack,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK
    } state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_F    = 2'd1;
    localparam logic [1:0] G_D    = 2'd2;
    localparam logic [1:0] G_G    = 2'd3;
    localparam logic [2:0] LIMIT  = 3'(STARVE_LIMIT);

    state_t      state;
    logic [2:0]  starve;
    logic        starved;
    logic        pf;
    logic        pd;
    logic        pg;
    logic [1:0]  win;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_we;

    assign starved = (starve == LIMIT);
    assign rdata   = (f_ack | d_ack | g_ack) ? mem_rdata : 16'h0000;

    // Eligible requests; the requester being acknowledged sits out
    always_comb begin
        pf = f_req;
        pd = d_req;
        pg = g_req;
        if (state == ACK) begin
            case (grant)
                G_F:     pf = 1'b0;
                G_D:     pd = 1'b0;
                G_G:     pg = 1'b0;
                default: ;
            endcase
        end
    end

    // Priority pick: debug > data > fetch, fetch first once starved
    always_comb begin
        win = G_NONE;
        if (starved && pf) begin
            win = G_F;
        end else if (pg) begin
            win = G_G;
        end else if (pd) begin
            win = G_D;
        end else if (pf) begin
            win = G_F;
        end
    end

    // Operands of the winner; fetch is always a read with zero data
    always_comb begin
        sel_addr  = f_addr;
        sel_we    = 1'b0;
        sel_wdata = 16'h0000;
        case (win)
            G_D: begin
                sel_addr  = d_addr;
                sel_we    = d_we;
                sel_wdata = d_wdata;
            end
            G_G: begin
                sel_addr  = g_addr;
                sel_we    = g_we;
                sel_wdata = g_wdata;
            end
            default: ;
        endcase
    end

    // Control FSM with registered outputs and fetch starvation counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            starve    <= 3'd0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            g_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            grant     <= G_NONE;
            busy      <= 1'b0;
        end else begin
            f_ack  <= 1'b0;
            d_ack  <= 1'b0;
            g_ack  <= 1'b0;
            mem_en <= 1'b0;
            unique case (state)
                IDLE, ACK: begin
                    if (win != G_NONE) begin
                        state     <= ISSUE;
                        grant     <= win;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_addr  <= sel_addr;
                        mem_we    <= sel_we;
                        mem_wdata <= sel_wdata;
                    end else begin
                        state <= IDLE;
                        grant <= G_NONE;
                        busy  <= 1'b0;
                    end
                    if (win == G_F) begin
                        starve <= 3'd0;
                    end else if (pf && !starved) begin
                        starve <= starve + 3'd1;
                    end
                end
                ISSUE: begin
                    state <= ACK;
                    f_ack <= (grant == G_F);
                    d_ack <= (grant == G_D);
                    g_ack <= (grant == G_G);
                end
                default: begin
                    state <= IDLE;
                    grant <= G_NONE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized
// traffic from three requesters against a shadow-memory reference.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        f_req = 1'b0, d_req = 1'b0, g_req = 1'b0;
    logic        d_we = 1'b0, g_we = 1'b0;
    logic [15:0] f_addr = '0, d_addr = '0, g_addr = '0;
    logic [15:0] d_wdata = '0, g_wdata = '0;
    logic        f_ack, d_ack, g_ack;
    logic [15:0] rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [1:0]  grant;
    logic        busy;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr),
        .g_wdata(g_wdata), .g_ack(g_ack),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    logic [15:0] ram    [0:65535];
    logic [15:0] shadow [0:65535];

    // synchronous single-port RAM
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    txn_t qf[$], qd[$], qg[$];
    int   checks = 0;
    int   failures = 0;

    logic chk_starve = 1'b0;
    logic f_wait = 1'b0;
    time  f_t = 0;
    time  last_pos = 0;
    int   others = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int who, input logic we,
                        input logic [15:0] addr, input logic [15:0] wdata);
        txn_t t;
        t.we    = we;
        t.addr  = addr;
        t.wdata = we ? wdata : 16'h0000;
        t.rdata = shadow[addr];
        if (we) shadow[addr] = wdata;
        case (who)
            1: qf.push_back(t);
            2: qd.push_back(t);
            default: qg.push_back(t);
        endcase
    endtask

    task automatic set_req(input int who, input logic req, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata);
        case (who)
            1: begin
                f_req = req; f_addr = addr;
            end
            2: begin
                d_req = req; d_we = we; d_addr = addr; d_wdata = wdata;
            end
            default: begin
                g_req = req; g_we = we; g_addr = addr; g_wdata = wdata;
            end
        endcase
    endtask

    function automatic logic ack_of(input int who);
        return (who == 1) ? f_ack : (who == 2) ? d_ack : g_ack;
    endfunction

    always @(posedge clk) last_pos = $time;

    // monitor: checks every issue and every ack against the queues
    always @(negedge clk) begin : mon
        txn_t t;
        logic ok;
        int   n;
        logic [1:0] code;
        if (rst) begin
            if (mem_en) begin
                ok = 1'b1;
                t  = '0;
                case (grant)
                    2'd1: if (qf.size() > 0) t = qf[0]; else ok = 1'b0;
                    2'd2: if (qd.size() > 0) t = qd[0]; else ok = 1'b0;
                    2'd3: if (qg.size() > 0) t = qg[0]; else ok = 1'b0;
                    default: ok = 1'b0;
                endcase
                check("issue_expected", ok, 1);
                if (ok) begin
                    check("mem_addr", mem_addr, t.addr);
                    check("mem_we", mem_we, t.we);
                    if (t.we || grant == 2'd1)
                        check("mem_wdata", mem_wdata, t.wdata);
                end
                if (chk_starve && f_wait) begin
                    if (grant == 2'd1) begin
                        check("starve_bound", others <= LIMIT, 1);
                        f_wait = 1'b0;
                        others = 0;
                    end else if (last_pos > f_t) begin
                        others++;
                    end
                end
            end
            n = int'(f_ack) + int'(d_ack) + int'(g_ack);
            if (n != 0) begin
                check("ack_onehot", n, 1);
                code = g_ack ? 2'd3 : d_ack ? 2'd2 : 2'd1;
                check("ack_grant", grant, code);
                ok = 1'b1;
                t  = '0;
                case (code)
                    2'd1: if (qf.size() > 0) t = qf.pop_front(); else ok = 1'b0;
                    2'd2: if (qd.size() > 0) t = qd.pop_front(); else ok = 1'b0;
                    default: if (qg.size() > 0) t = qg.pop_front(); else ok = 1'b0;
                endcase
                check("ack_expected", ok, 1);
                if (ok && !t.we) check("rdata", rdata, t.rdata);
            end
        end
    end

    task automatic do_req(input int who, input logic we,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rd);
        logic got;
        got = 1'b0;
        rd  = '0;
        @(negedge clk);
        push(who, we, addr, wdata);
        set_req(who, 1'b1, we, addr, wdata);
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (ack_of(who)) begin
                got = 1'b1;
                rd  = rdata;
            end
        end
        check("req_ack_seen", got, 1);
        @(posedge clk); #1;
        set_req(who, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic drive(input int who, input int n);
        logic [15:0] a, w;
        logic we, got;
        int gap;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                set_req(who, 1'b0, 1'b0, 16'h0, 16'h0);
                repeat (gap) @(posedge clk);
                #1;
            end
            case (who)
                1: begin
                    we = 1'b0; a = {8'h00, 8'($urandom)}; w = 16'h0;
                end
                2: begin
                    we = 1'($urandom); a = {8'h01, 8'($urandom)};
                    w = 16'($urandom);
                end
                default: begin
                    we = 1'($urandom); a = {8'h03, 8'($urandom)};
                    w = 16'($urandom);
                end
            endcase
            push(who, we, a, w);
            set_req(who, 1'b1, we, a, w);
            if (who == 1) begin
                f_t = $time;
                f_wait = 1'b1;
            end
            got = 1'b0;
            for (int c = 0; c < 60 && !got; c++) begin
                @(negedge clk);
                got = ack_of(who);
            end
            check("rnd_ack_seen", got, 1);
            @(posedge clk); #1;
        end
        set_req(who, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic fa, da, ga, busy_ok, seen, stop;
        int ag, ad, af, ngr, nf, nd, ng;
        int gseq[11];
        int exp_seq[11] = '{3, 2, 3, 2, 1, 3, 2, 3, 2, 3, 1};

        for (int i = 0; i < 65536; i++) begin
            ram[i]    = 16'(i) ^ 16'h5A3C;
            shadow[i] = 16'(i) ^ 16'h5A3C;
        end
        ram[16'h0010]    = 16'hA5A5;
        shadow[16'h0010] = 16'hA5A5;

        repeat (3) @(negedge clk);
        check("rst_acks", {f_ack, d_ack, g_ack}, 0);
        check("rst_ctrl", {mem_en, mem_we, busy, grant}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);

        // single read, arbitrated at the first edge out of reset
        @(negedge clk);
        rst = 1'b1;
        push(1, 1'b0, 16'h0010, 16'h0);
        set_req(1, 1'b1, 1'b0, 16'h0010, 16'h0);
        @(posedge clk);
        @(negedge clk);
        check("t1_issue_en", mem_en, 1);
        check("t1_issue_addr", mem_addr, 16'h0010);
        check("t1_grant", grant, 1);
        check("t1_busy", busy, 1);
        check("t1_no_early_ack", f_ack, 0);
        @(negedge clk);
        check("t1_en_one_cycle", mem_en, 0);
        check("t1_ack", f_ack, 1);
        check("t1_rdata", rdata, 16'hA5A5);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check("t1_idle_after", {busy, grant, f_ack, mem_en}, 0);

        // write then read back through the data port
        do_req(2, 1'b1, 16'h0200, 16'h1234, rd);
        do_req(2, 1'b0, 16'h0200, 16'h0000, rd);
        check("t2_readback", rd, 16'h1234);

        // three-way contention at one edge
        @(negedge clk);
        push(3, 1'b1, 16'h0330, 16'hBEEF);
        push(2, 1'b0, 16'h0120, 16'h0);
        push(1, 1'b0, 16'h0020, 16'h0);
        set_req(3, 1'b1, 1'b1, 16'h0330, 16'hBEEF);
        set_req(2, 1'b1, 1'b0, 16'h0120, 16'h0);
        set_req(1, 1'b1, 1'b0, 16'h0020, 16'h0);
        @(posedge clk);
        ag = 0; ad = 0; af = 0; busy_ok = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i <= 6 && !busy) busy_ok = 1'b0;
            ga = g_ack; da = d_ack; fa = f_ack;
            if (ga) ag = i;
            if (da) ad = i;
            if (fa) af = i;
            @(posedge clk); #1;
            if (ga) set_req(3, 1'b0, 1'b0, 16'h0, 16'h0);
            if (da) set_req(2, 1'b0, 1'b0, 16'h0, 16'h0);
            if (fa) set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        check("t3_debug_ack_cycle", ag, 2);
        check("t3_data_ack_cycle", ad, 4);
        check("t3_fetch_ack_cycle", af, 6);
        check("t3_no_idle_gap", busy_ok, 1);

        // starvation: fetch held while data/debug keep re-requesting
        stop = 1'b0; ngr = 0; nf = 0; nd = 0; ng = 0;
        @(negedge clk);
        push(1, 1'b0, 16'h0030, 16'h0);
        push(2, 1'b0, 16'h0140, 16'h0);
        push(3, 1'b0, 16'h0340, 16'h0);
        set_req(1, 1'b1, 1'b0, 16'h0030, 16'h0);
        set_req(2, 1'b1, 1'b0, 16'h0140, 16'h0);
        set_req(3, 1'b1, 1'b0, 16'h0340, 16'h0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (mem_en && ngr < 11) begin
                gseq[ngr] = int'(grant);
                ngr++;
            end
            if (ngr == 11) stop = 1'b1;
            fa = f_ack; da = d_ack; ga = g_ack;
            if (!f_req && !d_req && !g_req && !busy) break;
            @(posedge clk); #1;
            if (fa) begin
                if (stop) set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
                else begin
                    nf++;
                    push(1, 1'b0, 16'h0030 + 16'(nf), 16'h0);
                    set_req(1, 1'b1, 1'b0, 16'h0030 + 16'(nf), 16'h0);
                end
            end
            if (da) begin
                if (stop) set_req(2, 1'b0, 1'b0, 16'h0, 16'h0);
                else begin
                    nd++;
                    push(2, 1'b0, 16'h0140 + 16'(nd), 16'h0);
                    set_req(2, 1'b1, 1'b0, 16'h0140 + 16'(nd), 16'h0);
                end
            end
            if (ga) begin
                if (stop) set_req(3, 1'b0, 1'b0, 16'h0, 16'h0);
                else begin
                    ng++;
                    push(3, 1'b0, 16'h0340 + 16'(ng), 16'h0);
                    set_req(3, 1'b1, 1'b0, 16'h0340 + 16'(ng), 16'h0);
                end
            end
        end
        check("t4_grant_count", ngr, 11);
        for (int i = 0; i < 11; i++) begin
            if (i < ngr) check($sformatf("t4_grant_%0d", i), gseq[i], exp_seq[i]);
        end

        // reset in the middle of an ISSUE cycle
        @(negedge clk);
        set_req(2, 1'b1, 1'b1, 16'h0250, 16'h7777);
        @(posedge clk); #2;
        check("t5_in_issue", {mem_en, busy, grant}, {1'b1, 1'b1, 2'd2});
        rst = 1'b0;
        #1;
        check("t5_rst_ctrl", {f_ack, d_ack, g_ack, mem_en, mem_we, busy, grant}, 0);
        check("t5_rst_data", {mem_addr, mem_wdata}, 0);
        set_req(2, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (d_ack) seen = 1'b1;
        end
        check("t5_no_ack_after_release", seen, 0);
        do_req(2, 1'b0, 16'h0250, 16'h0, rd);
        check("t5_next_read", rd, 16'h0250 ^ 16'h5A3C);

        // idle with no requests
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t6_idle", {mem_en, busy, f_ack, d_ack, g_ack, grant}, 0);
        end

        // randomized traffic from all three requesters
        others = 0;
        f_wait = 1'b0;
        chk_starve = 1'b1;
        fork
            drive(1, 40);
            drive(2, 40);
            drive(3, 40);
        join
        chk_starve = 1'b0;
        repeat (4) @(negedge clk);
        check("sb_drained", qf.size() + qd.size() + qg.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
